if_fetch_buffer: RTL
====================

// Module: if_fetch_buffer
// PURPOSE
//   Downstream partner of the PC register: takes the fetch PC stream, issues in-order
//   requests to instruction memory, tracks outstanding reads and buffers returned
//   instructions with their PC for decode. Flush discards queued and in-flight fetches.
// PARAMETERS
//   XLEN             32  address/data width
//   DEPTH            4   instruction FIFO entries (power of 2, >=2)
//   MAX_OUTSTANDING  2   max granted-but-unanswered memory reads (power of 2, <=DEPTH)
// PORTS
//   clk          in   1     clock, all state on rising edge
//   reset        in   1     synchronous, active-high
//   fetch_pc     in   XLEN  PC to fetch
//   fetch_valid  in   1     fetch_pc valid
//   fetch_ready  out  1     fetch_pc consumed this cycle (= imem_req & imem_gnt)
//   flush        in   1     redirect: drop all buffered and in-flight fetches
//   imem_req     out  1     memory read request
//   imem_addr    out  XLEN  {fetch_pc[XLEN-1:2],2'b00}
//   imem_gnt     in   1     request accepted this cycle
//   imem_rvalid  in   1     read data valid; responses in request order
//   imem_rdata   in   XLEN  instruction word
//   id_valid     out  1     FIFO head valid
//   id_ready     in   1     decode accepts head
//   id_pc        out  XLEN  PC of head (full fetch_pc, low bits kept)
//   id_instr     out  XLEN  instruction of head
// BEHAVIOUR
//   - Reset: FIFO empty, outstanding o=0, discard d=0; id_valid=0, imem_req=0,
//     fetch_ready=0 during reset cycle regardless of inputs.
//   - imem_req = fetch_valid & ~flush & (o < MAX_OUTSTANDING) & (count + (o-d) < DEPTH);
//     uses registered count/o/d only (same-cycle pop does not free space). Combinational.
//   - On imem_req&imem_gnt: fetch_pc pushed into PC-tracking queue, o+1 next cycle.
//   - On imem_rvalid: PC-tracking head popped, o-1. If d>0 the response is dropped, d-1;
//     else {pc,rdata} pushed to instruction FIFO. Grant and rvalid same cycle: o unchanged.
//   - Min latency: gnt in cycle N, rvalid in N+1 -> id_valid in N+2 (FIFO registered).
//   - Decode handshake: entry popped when id_valid&id_ready; id_pc/id_instr stable while
//     id_valid&~id_ready. Push and pop same cycle on non-empty FIFO: count unchanged.
//   - Flush (cycle N): no request in N; FIFO emptied at N+1 (pop ignored);
//     d <= o - imem_rvalid (responses arriving in N are dropped). Flush while d>0 keeps
//     counting correctly: all outstanding become discards.
//   - Space check guarantees FIFO never overflows; push into full FIFO is an assertion.
//   - imem_rvalid with o==0: assertion failure, response ignored, counters unchanged.
//   - Reset mid-operation: all counters/queues cleared; late responses after reset are
//     the memory's responsibility (memory reset in same domain).
//   - Counters: o and d are $clog2(MAX_OUTSTANDING)+1 bits, count $clog2(DEPTH)+1 bits;
//     pointers wrap modulo depth.
// STRUCTURE
//   - Package lab8_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr;}
//     fetch_entry_t; constant NOP_INSTR = 32'h0000_0013.
//   - Sub-module fetch_fifo (parameterised sync FIFO: push/pop/full/empty/count),
//     instantiated twice: instruction FIFO (DEPTH) and PC-tracking queue (MAX_OUTSTANDING).
//   - Top holds o/d counters, request gating and flush logic.
// TESTING
//   1 Reset: hold reset 2 cycles with fetch_valid=1 -> imem_req=0, id_valid=0, fetch_ready=0.
//   2 Streaming: pc 0,4,8,C, gnt=1, rvalid 1 cycle later, id_ready=1 -> id_pc 0,4,8,C in
//     order, 1 per cycle, first id_valid 2 cycles after first grant.
//   3 Backpressure: id_ready=0, zero-latency memory -> after 4 entries imem_req=0, no loss;
//     release id_ready -> all 4 drain, fetch resumes.
//   4 Outstanding limit: gnt=1, rvalid held 0 -> exactly 2 grants, then imem_req=0 until rvalid.
//   5 Flush: 2 in flight + 2 queued, pulse flush -> next cycle id_valid=0, d=2; two later
//     responses dropped; next fetch pc 0x100 emerges as first id_pc.
//   6 Flush with simultaneous rvalid and id_ready -> that response dropped, d=o-1, no pop error.

Source files
------------

// File: rtl/lab8_pkg.sv
// lab8_pkg
//   Shared types and constants for the instruction-fetch slice.
//   fetch_entry_t : one decoded-side FIFO entry, the fetch PC paired with the
//                   instruction word that memory returned for it.
//   NOP_INSTR     : canonical RISC-V nop (addi x0,x0,0), presented to decode
//                   whenever there is no valid instruction at the FIFO head.
package lab8_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Parameterised synchronous FIFO with registered count.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     clear        : synchronous empty request, overrides push and pop
//     push, wdata  : write request and data (ignored when full)
//     pop          : read request (ignored when empty)
//     rdata        : data at the head, valid while !empty
//     full, empty  : occupancy flags derived from count
//     count        : number of stored entries, 0..DEPTH
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointer advance with an explicit wrap so that a single-entry queue
   // (one pointer bit, one slot) stays on slot zero.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Pointers and occupancy. Clear behaves like reset so a flush empties the
   // queue in one cycle regardless of what push/pop asked for.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   // Storage array; no reset needed because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Sits behind the PC register: turns the fetch PC stream into in-order
//   instruction-memory reads, remembers the PC of every granted read, and
//   queues {pc, instruction} pairs for decode. A flush drops everything
//   queued and marks every in-flight read as a discard.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     fetch_pc, fetch_valid      : PC to fetch and its valid
//     fetch_ready                : PC consumed this cycle (request granted)
//     flush                      : redirect, drop buffered and in-flight fetches
//     imem_req, imem_addr        : memory read request, word-aligned address
//     imem_gnt                   : memory accepted the request
//     imem_rvalid, imem_rdata    : in-order read response
//     id_valid, id_ready         : decode handshake on the FIFO head
//     id_pc, id_instr            : head entry (NOP_INSTR when no entry)
//   The entry type is 32-bit wide, so XLEN is expected to stay 32.
module if_fetch_buffer
   import lab8_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            fetch_valid,
   output logic            fetch_ready,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int SW = CW + 1;
   localparam int EW = $bits(fetch_entry_t);

   logic [OW-1:0]   out_cnt;
   logic [OW-1:0]   disc_cnt;
   logic [OW-1:0]   inflight;
   logic [SW-1:0]   space_used;
   logic [CW-1:0]   fifo_count;
   logic [OW-1:0]   pcq_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pcq_full;
   logic            pcq_empty;
   logic            grant;
   logic            resp_ok;
   logic            keep_resp;
   logic            id_pop;
   logic [XLEN-1:0] pcq_head;
   fetch_entry_t    fifo_in;
   fetch_entry_t    fifo_head;

   // Reads still owed to the FIFO are the outstanding ones minus those already
   // condemned by a flush; reserving their slots up front is what keeps the
   // FIFO from ever overflowing. Only registered state is used, so a pop in
   // the same cycle does not free space for a new request.
   assign inflight   = out_cnt - disc_cnt;
   assign space_used = SW'(fifo_count) + SW'(inflight);

   assign imem_req    = ~reset & fetch_valid & ~flush
                      & (out_cnt < OW'(MAX_OUTSTANDING))
                      & (space_used < SW'(DEPTH));
   assign imem_addr   = {fetch_pc[XLEN-1:2], 2'b00};
   assign grant       = imem_req & imem_gnt;
   assign fetch_ready = grant;

   // A response with nothing outstanding is spurious and is ignored entirely.
   // Responses arriving in the flush cycle are dropped along with the rest.
   assign resp_ok   = imem_rvalid & (out_cnt != '0);
   assign keep_resp = resp_ok & (disc_cnt == '0) & ~flush;

   assign fifo_in.pc    = pcq_head;
   assign fifo_in.instr = imem_rdata;

   assign id_valid = ~reset & ~fifo_empty;
   assign id_pop   = id_valid & id_ready;
   assign id_pc    = id_valid ? fifo_head.pc : '0;
   assign id_instr = id_valid ? fifo_head.instr : NOP_INSTR;

   // PC of every granted read, consumed in order as responses return.
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_pc_queue (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .push  (grant),
      .pop   (resp_ok),
      .wdata (fetch_pc),
      .rdata (pcq_head),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_count)
   );

   // Instructions ready for decode; flush empties it on the next edge.
   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_instr_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .push  (keep_resp),
      .pop   (id_pop),
      .wdata (fifo_in),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Outstanding and discard counters. A grant and a response in the same
   // cycle cancel out. On flush every read still outstanding after this
   // cycle's response becomes a discard, which also covers a flush arriving
   // while earlier discards are still pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_cnt  <= '0;
         disc_cnt <= '0;
      end else begin
         out_cnt <= out_cnt + OW'(grant) - OW'(resp_ok);
         if (flush)
            disc_cnt <= out_cnt - OW'(resp_ok);
         else if (resp_ok && disc_cnt != '0)
            disc_cnt <= disc_cnt - OW'(1);
      end
   end

   // Protocol and consistency properties.
   a_no_spurious_resp : assert property (@(posedge clk) disable iff (reset)
      !(imem_rvalid && out_cnt == '0));
   a_no_fifo_overflow : assert property (@(posedge clk) disable iff (reset)
      !(keep_resp && fifo_full && !id_pop));
   a_pcq_tracks_out   : assert property (@(posedge clk) disable iff (reset)
      (pcq_count == out_cnt) && !(grant && pcq_full) && !(resp_ok && pcq_empty));

endmodule
